// File: rtl/serial_shift_right.sv
// Iterative 32-bit right shifter (SRL/SRA), one bit per clock.
// Handshake: start accepted in IDLE/DONE; busy during SHIFT; done is a one-cycle pulse.
module serial_shift_right (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_result;
  logic [4:0]  r_count;
  logic        r_mode;
  logic        r_busy;
  logic        r_done;
  logic        w_accept;
  logic        w_step;

  always_comb begin
    w_accept     = start && (r_state != S_SHIFT);
    w_step       = (r_state == S_SHIFT) && (r_count != '0);
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (r_count == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_SHIFT);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_count  <= '0;
      r_mode   <= 1'b0;
    end else if (w_accept) begin
      r_result <= in;
      r_count  <= shamt;
      r_mode   <= arith;
    end else if (w_step) begin
      r_result <= {r_mode & r_result[31], r_result[31:1]};
      r_count  <= r_count - 5'd1;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_result;

endmodule

// File: tb/tb_serial_shift_right.sv
// Randomized self-checking bench for serial_shift_right against an arithmetic shift model.
module tb_serial_shift_right;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] d_in;
  logic [4:0]  d_shamt;
  logic        d_arith;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int unsigned n_tests;
  int unsigned n_fail;

  serial_shift_right dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (d_in),
    .shamt (d_shamt),
    .arith (d_arith),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n,
                                            input logic ar);
    logic signed [31:0] sa;
    sa = a;
    if (ar) return sa >>> n;
    return a >> n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from the current cycle (IDLE or DONE) and follows it to done.
  // With idle_after=0 the caller chains the next op straight out of DONE.
  task automatic run_op(input logic [31:0] a, input logic [4:0] n, input logic ar,
                        input bit idle_after);
    logic [31:0] exp;
    int unsigned edges;
    int unsigned busy_cyc;
    exp = ref_shift(a, n, ar);
    start = 1'b1; d_in = a; d_shamt = n; d_arith = ar;
    tick();
    edges = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cyc++;
      start   = 1'($urandom_range(0, 1));
      d_in    = $urandom;
      d_shamt = 5'($urandom);
      d_arith = 1'($urandom);
      tick();
      edges++;
    end
    start = 1'b0;
    check("latency", edges, 32'(n) + 32'd1);
    check("busy_cycles", busy_cyc, 32'(n) + 32'd1);
    check("result", out, exp);
    check("busy_at_done", 32'(busy), 32'd0);
    if (idle_after) begin
      tick();
      check("done_pulse_len", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("held_result", out, exp);
    end
  endtask

  initial begin
    int unsigned stray_done;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; start = 1'b0; d_in = '0; d_shamt = '0; d_arith = 1'b0;
    tick();
    start = 1'b1; d_in = 32'hDEAD_BEEF; d_shamt = 5'd3;
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", out, 32'h0);
    reset = 1'b0; start = 1'b0;
    tick();

    run_op(32'h8000_0000, 5'd4,  1'b1, 1'b1);
    run_op(32'h8000_0000, 5'd4,  1'b0, 1'b1);
    run_op(32'h8000_0000, 5'd31, 1'b1, 1'b1);
    run_op(32'h1234_ABCD, 5'd0,  1'b0, 1'b1);
    run_op(32'hFFFF_0000, 5'd8,  1'b0, 1'b1);
    run_op(32'hF000_0000, 5'd31, 1'b0, 1'b0);
    run_op(32'hF000_0000, 5'd1,  1'b1, 1'b1);

    // Reset in the middle of a long shift, with start also high on the reset edge.
    start = 1'b1; d_in = 32'hCAFE_F00D; d_shamt = 5'd10; d_arith = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1; start = 1'b1;
    tick();
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_out", out, 32'h0);
    reset = 1'b0; start = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 14; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray_done++;
      tick();
    end
    check("midreset_no_done", stray_done, 32'd0);
    run_op(32'h0000_0010, 5'd4, 1'b0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic [4:0]  n;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
      n = 5'($urandom);
      run_op(a, n, 1'($urandom), bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    tick();
    tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_shift_right.md
SERIAL_SHIFT_RIGHT -- requirements
Module: serial_shift_right

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on this edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 in  input  32  operand (rt value); captured when start is accepted.
REQ-006 shamt  input  5  shift amount 0..31; captured when start is accepted.
REQ-007 arith  input  1  1=SRA (sign fill), 0=SRL (zero fill); captured when start is accepted.
REQ-008 busy  output  1  high while a shift is in progress.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 out  output  32  shift result; valid when done=1, held until the next accepted start.

Function
REQ-011 The block SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 Accept: on an edge with start=1 and state IDLE or DONE, the block SHALL latch in into the result register, shamt into a 5-bit down-counter and arith into a mode flag, then enter SHIFT.
REQ-013 SHIFT, counter != 0: at each edge the result register SHALL shift right by one bit, MSB fill = mode ? result[31] : 0, and the counter SHALL decrement by 1.
REQ-014 SHIFT, counter == 0: at the next edge the block SHALL enter DONE without shifting.
REQ-015 DONE SHALL last exactly one cycle, then go to IDLE, unless start=1 on that edge, in which case REQ-012 applies (back-to-back operation).
REQ-016 Latency: for an accept edge E0 and shamt=N, done SHALL be high during the cycle following edge E(N+1); total 0..31 gives 1..32 edges.
REQ-017 busy SHALL be 1 exactly when state=SHIFT; done SHALL be 1 exactly when state=DONE; both outputs SHALL be registered.
REQ-018 start while busy=1 SHALL be ignored; in, shamt and arith changes during SHIFT SHALL have no effect.
REQ-019 shamt=0 SHALL give out=in with done one edge after the accept (REQ-016, N=0).
REQ-020 out SHALL equal the result register at all times; the value SHALL be defined only while done=1 and SHALL be held in IDLE.
REQ-021 Arithmetic SHALL stay 32-bit; the result SHALL equal in>>shamt (SRL) or $signed(in)>>>shamt (SRA) exactly.

Reset
REQ-022 reset=1 at an edge SHALL force state=IDLE, busy=0, done=0, out=0x00000000, counter=0 and mode=0, regardless of the current state.
REQ-023 Reset SHALL take priority over start on the same edge; a shift interrupted by reset SHALL produce no done pulse.
REQ-024 The first accepted start after reset deasserts SHALL behave identically to any other start.

Verification
REQ-025 in=0x80000000, shamt=4, arith=1 -> busy for 5 cycles; done at edge E5; out=0xF8000000.
REQ-026 Same stimulus with arith=0 -> out=0x08000000 at edge E5; in=0x80000000, shamt=31, arith=1 -> out=0xFFFFFFFF, done at edge E32.
REQ-027 in=0x1234ABCD, shamt=0 -> done at edge E1 with out=0x1234ABCD; busy high for one cycle.
REQ-028 Start in=0xFFFF0000, shamt=8, arith=0, then pulse start with in=0x1 at edge E3 -> second start ignored; out=0x00FFFF00 at edge E9.
REQ-029 Reset at edge E2 of a shamt=10 operation -> no done pulse; out=0, busy=0; a new start with in=0x10, shamt=4, arith=0 gives out=0x1 at edge E5.
REQ-030 Start asserted during DONE with in=0xF0000000, shamt=1, arith=1 -> accepted back-to-back; out=0xF8000000 with done two edges later.
